// File: rtl/dmem_ctrl.sv
// Handshaked byte/half/word data memory for the multi-cycle MIPS core.
// Latches one request, optionally waits, performs a single ACCESS cycle and holds the response.
module dmem_ctrl #(
    parameter int DEPTH          = 32,
    parameter int ADDR_W         = 7,
    parameter int WAIT_CYCLES    = 0,
    parameter int BIG_ENDIAN     = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;
    localparam int         LAT_W    = ADDR_W + 36;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              fault_q, fault_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [31:0]       mem_q [DEPTH];

    logic              write_l, signed_l;
    logic [1:0]        size_l;
    logic [ADDR_W-1:0] addr_l;
    logic [31:0]       wdata_l;
    logic [ADDR_W-3:0] widx;
    logic [1:0]        off;
    logic              req_fault, mem_we;
    logic [4:0]        shamt;
    logic [31:0]       mask, rd_word, shifted, ld_val, wr_word;

    assign {write_l, size_l, signed_l, addr_l, wdata_l} = lat_q;
    assign widx = addr_l[ADDR_W-1:2];
    assign off  = addr_l[1:0];

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q;

    always_comb begin
        req_fault = (req_size == 2'b11)
                 || (req_size == 2'b01 && req_addr[0])
                 || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                 || (32'(req_addr[ADDR_W-1:2]) >= 32'(DEPTH));
    end

    // Lane position of the addressed byte/half inside the stored word.
    always_comb begin
        mask  = 32'hFFFF_FFFF;
        shamt = 5'd0;
        case (size_l)
            2'b00: begin
                mask  = 32'h0000_00FF;
                shamt = (BIG_ENDIAN != 0) ? 5'd24 - {off, 3'b000} : {off, 3'b000};
            end
            2'b01: begin
                mask  = 32'h0000_FFFF;
                shamt = (BIG_ENDIAN != 0) ? {~off[1], 4'b0000} : {off[1], 4'b0000};
            end
            default: ;
        endcase
        rd_word = mem_q[widx];
        shifted = rd_word >> shamt;
        case (size_l)
            2'b00:   ld_val = {{24{shifted[7] & signed_l}}, shifted[7:0]};
            2'b01:   ld_val = {{16{shifted[15] & signed_l}}, shifted[15:0]};
            default: ld_val = rd_word;
        endcase
        wr_word = (rd_word & ~(mask << shamt)) | ((wdata_l & mask) << shamt);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        lat_d   = lat_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    lat_d = {req_write, req_size, req_signed, req_addr, req_wdata};
                    if (req_fault) begin
                        state_d = S_RESP;
                        fault_d = 1'b1;
                        rdata_d = 32'd0;
                    end else if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                state_d = S_RESP;
                fault_d = 1'b0;
                rdata_d = write_l ? 32'd0 : ld_val;
                mem_we  = write_l;
            end
            default: begin
                if (resp_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            fault_q <= 1'b0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            lat_q   <= lat_d;
        end
    end

    // mem_we comes from registered state, so an aborted store can never write.
    generate
        if (CLEAR_ON_RESET != 0) begin : g_clr
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
                end else if (mem_we) begin
                    mem_q[widx] <= wr_word;
                end
            end
        end else begin : g_keep
            always_ff @(posedge clk) begin
                if (mem_we) mem_q[widx] <= wr_word;
            end
        end
    endgenerate
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised, handshaked data memory for the multi-cycle MIPS core, the next generation of the fixed 32-word data memory. It serves byte, half-word and word loads and stores with sign/zero extension, selectable endianness, configurable depth and configurable wait states. It also detects misaligned and out-of-range accesses. It sits between the core's memory-stage control FSM and the load/store datapath, with valid/ready handshakes on both the request and the response side.

## Interface
- DEPTH, 32: number of 32-bit words; 1..2**(ADDR_W-2).
- ADDR_W, 7: byte-address width.
- WAIT_CYCLES, 0: extra wait states per legal access; 0..15.
- BIG_ENDIAN, 0: 0 = byte offset 0 in bits [7:0]; 1 = byte offset 0 in bits [31:24].
- CLEAR_ON_RESET, 1: 1 = reset zeroes every word; 0 = contents untouched by reset.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  sign-extend loads; ignored for word and for stores.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  32  load result, right-aligned and extended; 0 for stores and faults.
- resp_fault  out  1  request was rejected; memory unchanged.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP. req_ready is 1 only in IDLE. resp_valid is 1 only in RESP.
- Acceptance: at a rising edge in IDLE with req_valid=1, all req_* fields are latched. Later changes on req_* are ignored.
- Fault check at acceptance:
  - size 11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - word index addr[ADDR_W-1:2] >= DEPTH.
- Faulted request: go directly to RESP with resp_fault=1 and resp_rdata=0. No memory access occurs.
- Legal request: go to WAIT if WAIT_CYCLES>0, else to ACCESS. WAIT lasts exactly WAIT_CYCLES cycles, counted by a down-counter loaded at acceptance. After WAIT, go to ACCESS.
- ACCESS (one cycle); at its closing edge:
  - A store updates only the addressed lanes of the word. Other lanes are preserved.
  - A load captures the extracted, extended value into resp_rdata.
  - The state moves to RESP.
- Lane mapping, offset o = addr[1:0]:
  - Little-endian byte: bits [8o+7:8o].
  - Little-endian half: o=0 → [15:0], o=2 → [31:16].
  - Big-endian mirrors this: byte o → bits [31-8o:24-8o]; half o=0 → [31:16], o=2 → [15:0].
- Extension: byte → {24{b[7]&signed}, b}; half → {16{h[15]&signed}, h}; word passes through.
- RESP: hold resp_valid, resp_rdata and resp_fault stable until a rising edge with resp_ready=1, then go to IDLE. resp_rdata and resp_fault keep their values after the handshake until the next response.
- No new request is accepted in the RESP→IDLE handoff cycle. Maximum throughput is one request per WAIT_CYCLES+3 cycles.

## Timing
- Reset, immediate and asynchronous:
  - state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_fault=0; wait counter=0.
  - Memory is zeroed if CLEAR_ON_RESET=1.
- Reset mid-operation: the in-flight request is abandoned. A store not yet past its ACCESS edge never writes. No response is produced.
- Legal-access latency: with acceptance at edge E0, resp_valid rises after edge E0+WAIT_CYCLES+1.
- Fault latency: resp_valid rises after E0 itself.
- Read-after-write: a load accepted after a store's response sees the stored data.
- Combinational paths: none from req_* or resp_ready to any output. req_ready and resp_valid are decoded from registered state.

## Test plan
- LE, W=0:
  - Store word 0x8899AABB at 0x08, then load byte 0x0B.
  - signed → 0xFFFFFF88; unsigned → 0x00000088.
  - Load half 0x0A signed → 0xFFFF8899.
  - Each response arrives one edge after acceptance.
- LE, half store:
  - Store half 0x00001234 at 0x0A over 0x8899AABB, then load word 0x08 → 0x1234AABB.
  - Store byte 0x000000CC at 0x09, then load word → 0x1234CCBB.
- BIG_ENDIAN=1:
  - Store word 0x8899AABB at 0x04.
  - Load byte 0x04 unsigned → 0x00000088.
  - Load half 0x06 unsigned → 0x0000AABB.
- Faults, DEPTH=24:
  - Half at 0x09, word at 0x0E, size 11, and word at 0x60 each give resp_fault=1, resp_rdata=0 one edge after acceptance.
  - A following word load confirms the previously stored contents are unchanged.
- WAIT_CYCLES=3 with backpressure:
  - resp_valid rises 4 edges after acceptance.
  - Hold resp_ready=0 for 5 cycles: response stable, req_ready=0, new req_valid ignored.
  - resp_ready=1 returns the block to IDLE on the next edge.
- Reset abort:
  - Assert rst during WAIT of a store of 0xDEADBEEF to 0x10 with CLEAR_ON_RESET=0.
  - Outputs reach their reset values immediately.
  - A later load of 0x10 returns the old value.
